// File: rtl/manchester_tx_pkg.sv
// Shared types and constants for the Manchester frame transmitter.
package manchester_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_PAYLOAD,
      ST_GAP
   } state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
   localparam int         SYMBOL_W      = 16;

endpackage

// File: rtl/manchester_encoder.sv
// Combinational byte-to-symbol Manchester encoder, MSB first: 1 -> 10, 0 -> 01.
module manchester_encoder
   import manchester_tx_pkg::*;
(
   input  logic [7:0]          data,
   output logic [SYMBOL_W-1:0] symbol
);

   always_comb begin
      symbol = '0;
      for (int i = 0; i < 8; i++) begin
         symbol[2*i +: 2] = data[i] ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/manchester_frame_scheduler.sv
// Frame sequencer feeding the 8:1 OSERDES: preamble, SFD, streamed payload, idle gap.
// state       | meaning
// ST_IDLE     | line idle, waiting for enable && s_tvalid
// ST_PREAMBLE | sending PREAMBLE_BYTES symbols of 0xAA
// ST_SFD      | sending the start-of-frame delimiter symbol
// ST_PAYLOAD  | one source byte per symbol until tlast or underrun
// ST_GAP      | GAP_WORDS idle words before a new frame may start
module manchester_frame_scheduler
   import manchester_tx_pkg::*;
#(
   parameter int         PREAMBLE_BYTES = 2,
   parameter logic [7:0] SFD            = 8'hD5,
   parameter int         GAP_WORDS      = 4,
   parameter logic [7:0] IDLE_WORD      = 8'h00
) (
   input  logic       clk_div,
   input  logic       aresetn,
   input  logic       enable,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   output logic       s_tready,
   output logic [7:0] serdes_word,
   output logic       frame_active,
   output logic       underrun
);

   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_WORDS - 1);

   state_t              state, state_nxt;
   logic                phase, phase_nxt;
   logic [7:0]          cnt, cnt_nxt;
   logic                last_q, last_nxt;
   logic [7:0]          lo_half;
   logic [7:0]          sel_byte;
   logic [SYMBOL_W-1:0] symbol;
   logic [7:0]          word_nxt;
   logic                active_nxt;
   logic                underrun_nxt;

   always_comb begin
      case (state)
         ST_PREAMBLE: sel_byte = PREAMBLE_BYTE;
         ST_SFD:      sel_byte = SFD;
         default:     sel_byte = s_tdata;
      endcase
   end

   manchester_encoder u_enc (
      .data   (sel_byte),
      .symbol (symbol)
   );

   assign s_tready = (state == ST_PAYLOAD) && !phase;

   always_ff @(posedge clk_div or negedge aresetn) begin
      if (!aresetn) begin
         state        <= ST_IDLE;
         phase        <= 1'b0;
         cnt          <= '0;
         last_q       <= 1'b0;
         lo_half      <= '0;
         serdes_word  <= IDLE_WORD;
         frame_active <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         cnt          <= cnt_nxt;
         last_q       <= last_nxt;
         if (!phase) lo_half <= symbol[7:0];
         serdes_word  <= word_nxt;
         frame_active <= active_nxt;
         underrun     <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      cnt_nxt   = cnt;
      last_nxt  = last_q;
      case (state)
         ST_IDLE: begin
            phase_nxt = 1'b0;
            if (enable && s_tvalid) begin
               state_nxt = ST_PREAMBLE;
               cnt_nxt   = PRE_LAST;
            end
         end
         ST_PREAMBLE: begin
            phase_nxt = ~phase;
            if (phase) begin
               if (cnt == '0) state_nxt = ST_SFD;
               else           cnt_nxt   = cnt - 8'd1;
            end
         end
         ST_SFD: begin
            phase_nxt = ~phase;
            if (phase) state_nxt = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (!phase) begin
               if (s_tvalid) begin
                  phase_nxt = 1'b1;
                  last_nxt  = s_tlast;
               end else begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = GAP_LAST;
               end
            end else begin
               phase_nxt = 1'b0;
               if (last_q) begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = GAP_LAST;
               end
            end
         end
         ST_GAP: begin
            phase_nxt = 1'b0;
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - 8'd1;
         end
         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = 1'b0;
         end
      endcase
   end

   // Phase 0 puts the high half on the line, phase 1 the half latched a cycle earlier.
   always_comb begin
      word_nxt     = IDLE_WORD;
      active_nxt   = 1'b0;
      underrun_nxt = 1'b0;
      case (state)
         ST_PREAMBLE, ST_SFD: begin
            active_nxt = 1'b1;
            word_nxt   = phase ? lo_half : symbol[15:8];
         end
         ST_PAYLOAD: begin
            if (phase) begin
               active_nxt = 1'b1;
               word_nxt   = lo_half;
            end else if (s_tvalid) begin
               active_nxt = 1'b1;
               word_nxt   = symbol[15:8];
            end else begin
               underrun_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_manchester_frame_scheduler.sv
// Self-checking bench: per-cycle comparison of the word stream against a frame-level model.
module tb_manchester_frame_scheduler;

   localparam int         PRE_BYTES = 2;
   localparam logic [7:0] SFD_BYTE  = 8'hD5;
   localparam int         GAP_W     = 4;
   localparam logic [7:0] IDLE_W    = 8'h00;

   logic       clk_div;
   logic       aresetn;
   logic       enable;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic [7:0] serdes_word;
   logic       frame_active;
   logic       underrun;

   manchester_frame_scheduler #(
      .PREAMBLE_BYTES (PRE_BYTES),
      .SFD            (SFD_BYTE),
      .GAP_WORDS      (GAP_W),
      .IDLE_WORD      (IDLE_W)
   ) dut (
      .clk_div      (clk_div),
      .aresetn      (aresetn),
      .enable       (enable),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready),
      .serdes_word  (serdes_word),
      .frame_active (frame_active),
      .underrun     (underrun)
   );

   initial clk_div = 1'b0;
   always #5 clk_div = ~clk_div;

   int          n_cmp = 0;
   int          n_err = 0;
   int          tready_seen = 0;
   bit          pend_pop = 0;
   bit          src_en = 0;
   logic [10:0] exp_q[$];   // {underrun, s_tready, frame_active, word}
   logic [8:0]  src_q[$];   // {tlast, data}
   logic [7:0]  acc_q[$];
   logic [7:0]  sent_q[$];

   // Manchester symbol as arithmetic: all-zero byte is 0x5555, each set bit i adds 1<<(2i).
   function automatic logic [15:0] man(input logic [7:0] b);
      logic [15:0] s;
      s = 16'h5555;
      for (int i = 0; i < 8; i++)
         if (b[i]) s = s + (16'd1 << (2 * i));
      return s;
   endfunction

   function automatic logic [10:0] ent(input logic u, input logic r, input logic a,
                                       input logic [7:0] w);
      return {u, r, a, w};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic exp_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(ent(1'b0, 1'b0, 1'b0, IDLE_W));
   endtask

   task automatic exp_hdr();
      logic [15:0] s;
      exp_idle(1);
      s = man(8'hAA);
      for (int p = 0; p < PRE_BYTES; p++) begin
         exp_q.push_back(ent(1'b0, 1'b0, 1'b1, s[15:8]));
         exp_q.push_back(ent(1'b0, 1'b0, 1'b1, s[7:0]));
      end
      s = man(SFD_BYTE);
      exp_q.push_back(ent(1'b0, 1'b0, 1'b1, s[15:8]));
      exp_q.push_back(ent(1'b0, 1'b1, 1'b1, s[7:0]));
   endtask

   task automatic exp_byte(input logic [7:0] d, input logic last);
      logic [15:0] s;
      s = man(d);
      exp_q.push_back(ent(1'b0, 1'b0, 1'b1, s[15:8]));
      exp_q.push_back(ent(1'b0, !last, 1'b1, s[7:0]));
      if (last) exp_idle(GAP_W);
   endtask

   task automatic exp_underrun();
      exp_q.push_back(ent(1'b1, 1'b0, 1'b0, IDLE_W));
      exp_idle(GAP_W);
   endtask

   task automatic src_byte(input logic [7:0] d, input logic last);
      src_q.push_back({last, d});
      sent_q.push_back(d);
   endtask

   task automatic drive();
      logic [8:0] hd;
      if (src_en && src_q.size() > 0) begin
         hd       = src_q[0];
         s_tvalid = 1'b1;
         s_tlast  = hd[8];
         s_tdata  = hd[7:0];
      end else begin
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         s_tdata  = 8'($urandom);
      end
      pend_pop = s_tready && s_tvalid;
   endtask

   task automatic run_cycles(input string tag, input int n);
      logic [8:0]  hd;
      logic [10:0] obs;
      logic [10:0] expv;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_div);
         if (pend_pop && src_q.size() > 0) begin
            hd = src_q.pop_front();
            acc_q.push_back(hd[7:0]);
         end
         pend_pop = 0;
         obs = {underrun, s_tready, frame_active, serdes_word};
         if (exp_q.size() > 0) expv = exp_q.pop_front();
         else                  expv = ent(1'b0, 1'b0, 1'b0, IDLE_W);
         chk(tag, 32'(obs), 32'(expv));
         if (s_tready) tready_seen++;
         drive();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int         n;

      aresetn  = 1'b0;
      enable   = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 8'h00;

      run_cycles("in_reset", 3);
      aresetn = 1'b1;
      enable  = 1'b1;
      run_cycles("idle_no_valid", 8);

      // Directed frame {0x00, 0x0F last}
      tready_seen = 0;
      src_byte(8'h00, 1'b0);
      src_byte(8'h0F, 1'b1);
      exp_hdr();
      exp_byte(8'h00, 1'b0);
      exp_byte(8'h0F, 1'b1);
      src_en = 1;
      drive();
      run_cycles("frame_00_0f", 20);
      chk("tready_count", 32'(tready_seen), 32'd2);

      // Source runs dry after the first payload byte
      src_byte(8'h00, 1'b0);
      exp_hdr();
      exp_byte(8'h00, 1'b0);
      exp_underrun();
      drive();
      run_cycles("underrun", 20);

      // Back-to-back frames with an always-valid source
      acc_q.delete();
      sent_q.delete();
      for (int f = 0; f < 5; f++) begin
         n = (f < 3) ? 2 : int'($urandom_range(1, 4));
         exp_hdr();
         for (int j = 0; j < n; j++) begin
            d = 8'($urandom);
            src_byte(d, j == n - 1);
            exp_byte(d, j == n - 1);
         end
      end
      drive();
      run_cycles("back_to_back", exp_q.size() + 5);
      chk("sb_count", 32'(acc_q.size()), 32'(sent_q.size()));
      for (int i = 0; i < acc_q.size() && i < sent_q.size(); i++)
         chk("sb_byte", 32'(acc_q[i]), 32'(sent_q[i]));

      // enable gates the start; dropping it mid-payload does not cut the frame
      enable = 1'b0;
      for (int j = 0; j < 3; j++) src_byte(8'($urandom), j == 2);
      drive();
      run_cycles("enable_low", 6);
      enable = 1'b1;
      exp_hdr();
      for (int j = 0; j < 3; j++) exp_byte(sent_q[sent_q.size() - 3 + j], j == 2);
      run_cycles("enable_start", 12);
      enable = 1'b0;
      run_cycles("enable_drop", 15);

      // Asynchronous reset during payload
      enable = 1'b1;
      exp_hdr();
      for (int j = 0; j < 3; j++) begin
         d = 8'($urandom);
         src_byte(d, j == 2);
         exp_byte(d, j == 2);
      end
      drive();
      run_cycles("pre_reset", 9);
      aresetn = 1'b0;
      #1;
      chk("rst_word", 32'(serdes_word), 32'(IDLE_W));
      chk("rst_active", 32'(frame_active), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd0);
      exp_q.delete();
      src_q.delete();
      pend_pop = 0;
      drive();
      run_cycles("held_reset", 2);
      aresetn = 1'b1;
      run_cycles("post_reset", 4);
      exp_hdr();
      for (int j = 0; j < 2; j++) begin
         d = 8'($urandom);
         src_byte(d, j == 1);
         exp_byte(d, j == 1);
      end
      drive();
      run_cycles("fresh_frame", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
